// File: rtl/ex_arbiter_pkg.sv
// ex_arbiter_pkg: shared cause codes, m_exc bit positions, the default
// exception vector and the types used by the exception commit unit.
package ex_arbiter_pkg;

  // CP0 Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  // bit positions inside m_exc
  localparam int MEXC_FADEL = 0;
  localparam int MEXC_RI    = 1;
  localparam int MEXC_OV    = 2;
  localparam int MEXC_SYS   = 3;
  localparam int MEXC_BP    = 4;
  localparam int MEXC_LADEL = 5;
  localparam int MEXC_SADES = 6;
  localparam int MEXC_W     = 7;

  localparam logic [31:0] EX_VECTOR_DEFAULT = 32'hBFC0_0380;

  // which address feeds BadVAddr
  typedef enum logic [1:0] {
    BAD_NONE = 2'd0,
    BAD_PC   = 2'd1,
    BAD_ADDR = 2'd2
  } bad_sel_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } ex_state_e;

  // registered commit record presented to CP0
  typedef struct packed {
    logic        valid;
    logic        eret;
    logic        bd;
    logic [4:0]  excode;
    logic [31:0] epc;
    logic [31:0] badvaddr;
  } ex_commit_t;

  // EPC points at the branch when the faulting instruction sits in its delay slot
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/ex_arbiter_prio.sv
// ex_prio: combinational exception priority encoder.
//   int_pend : sampled interrupt request
//   m_exc    : per-cause flags of the MEM instruction
//   m_eret   : MEM instruction is eret
//   hit      : something must be committed
//   excode   : cause code of the winning source (0 for eret)
//   is_eret  : eret wins (no interrupt, no fault)
//   bad_sel  : BadVAddr source for the winning cause
module ex_prio
  import ex_arbiter_pkg::*;
(
  input  logic              int_pend,
  input  logic [MEXC_W-1:0] m_exc,
  input  logic              m_eret,
  output logic              hit,
  output logic [4:0]        excode,
  output logic              is_eret,
  output bad_sel_e          bad_sel
);

  always_comb begin
    hit     = int_pend | (|m_exc) | m_eret;
    excode  = 5'h00;
    is_eret = 1'b0;
    bad_sel = BAD_NONE;
    if (int_pend) begin
      excode = EXC_INT;
    end else if (m_exc[MEXC_FADEL]) begin
      excode  = EXC_ADEL;
      bad_sel = BAD_PC;
    end else if (m_exc[MEXC_RI]) begin
      excode = EXC_RI;
    end else if (m_exc[MEXC_OV]) begin
      excode = EXC_OV;
    end else if (m_exc[MEXC_SYS]) begin
      excode = EXC_SYS;
    end else if (m_exc[MEXC_BP]) begin
      excode = EXC_BP;
    end else if (m_exc[MEXC_LADEL]) begin
      excode  = EXC_ADEL;
      bad_sel = BAD_ADDR;
    end else if (m_exc[MEXC_SADES]) begin
      excode  = EXC_ADES;
      bad_sel = BAD_ADDR;
    end else if (m_eret) begin
      is_eret = 1'b1;
    end
  end

endmodule

// File: rtl/ex_arbiter.sv
// ex_arbiter: exception commit and flush control at the MEM/WB boundary.
// Picks the highest-priority cause of the MEM instruction (or the sampled
// interrupt), emits a one-cycle registered commit to CP0, then holds flush
// for FLUSH_CYCLES cycles with a stable redirect PC.
//   clk, resetn        : clock, async active-low reset
//   m_valid, stall     : MEM occupancy / hold
//   m_pc, m_bd, m_exc  : MEM instruction PC, delay-slot flag, fault flags
//   m_eret, m_addr     : eret marker, load/store data address
//   int_req, cp0_epc   : CP0 interrupt level, current EPC
//   ex_*               : registered commit record for CP0
//   flush, redirect_pc : kill younger stages, fetch target
module ex_arbiter
  import ex_arbiter_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EX_VECTOR    = EX_VECTOR_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m_valid,
  input  logic              stall,
  input  logic [31:0]       m_pc,
  input  logic              m_bd,
  input  logic [MEXC_W-1:0] m_exc,
  input  logic              m_eret,
  input  logic [31:0]       m_addr,
  input  logic              int_req,
  input  logic [31:0]       cp0_epc,
  output logic              ex_valid,
  output logic              ex_eret,
  output logic              ex_bd,
  output logic [4:0]        ex_excode,
  output logic [31:0]       ex_epc,
  output logic [31:0]       ex_badvaddr,
  output logic              flush,
  output logic [31:0]       redirect_pc
);

  ex_state_e   state;
  logic [3:0]  cnt;
  logic        int_pend;
  ex_commit_t  cmt;

  logic        p_hit;
  logic [4:0]  p_excode;
  logic        p_is_eret;
  bad_sel_e    p_bad_sel;

  ex_prio u_prio (
    .int_pend (int_pend),
    .m_exc    (m_exc),
    .m_eret   (m_eret),
    .hit      (p_hit),
    .excode   (p_excode),
    .is_eret  (p_is_eret),
    .bad_sel  (p_bad_sel)
  );

  logic        commit;
  logic [31:0] bad_nxt;

  assign commit = (state == ST_IDLE) & m_valid & ~stall & p_hit;

  always_comb begin
    bad_nxt = 32'h0;
    case (p_bad_sel)
      BAD_PC:   bad_nxt = m_pc;
      BAD_ADDR: bad_nxt = m_addr;
      default:  bad_nxt = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      int_pend    <= 1'b0;
      cmt         <= '0;
      flush       <= 1'b0;
      redirect_pc <= 32'h0;
    end else begin
      int_pend  <= int_req;
      cmt.valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (commit) begin
            cmt.valid    <= 1'b1;
            cmt.eret     <= p_is_eret;
            cmt.bd       <= p_is_eret ? 1'b0 : m_bd;
            cmt.excode   <= p_excode;
            cmt.epc      <= epc_of(m_pc, m_bd);
            cmt.badvaddr <= bad_nxt;
            redirect_pc  <= p_is_eret ? cp0_epc : EX_VECTOR;
            flush        <= 1'b1;
            cnt          <= 4'(FLUSH_CYCLES - 1);
            state        <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // stall has no say here; the countdown always runs
          if (cnt == 4'd0) begin
            flush <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ex_valid    = cmt.valid;
  assign ex_eret     = cmt.eret;
  assign ex_bd       = cmt.bd;
  assign ex_excode   = cmt.excode;
  assign ex_epc      = cmt.epc;
  assign ex_badvaddr = cmt.badvaddr;

endmodule
